// File: rtl/uart_pkg.sv
// Shared UART definitions: parity mode codes and receiver state encoding.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
module uart_rx_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Preset to 1 so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[STAGES-2:0], d_i};
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 5-9 data bits LSB first, optional parity, 1-2 stop bits.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  if (CLKS_PER_BIT < 8 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || SYNC_STAGES < 2) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID   = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic          ODD_FLIP  = 1'(PARITY == PARITY_ODD);

  logic rxs;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx),
    .q_o (rxs)
  );

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_out_q, perr_out_d;
  logic                 ferr_out_q, ferr_out_d;
  logic                 tick, ferr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      stop_q     <= 1'b0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      stop_q     <= stop_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + 1'b1;
    bit_d      = bit_q;
    stop_d     = stop_q;
    shreg_d    = shreg_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    tick       = (cnt_q == CNT_LAST);
    ferr_nx    = ferr_q | ~rxs;

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        bit_d  = '0;
        stop_d = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d   = '0;
          state_d = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d = '0;
          // Right shift: after DATA_BITS samples the first bit lands in bit 0.
          shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == BIT_LAST) state_d = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          perr_d  = ^{shreg_q, rxs} ^ ODD_FLIP;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d  = '0;
          ferr_d = ferr_nx;
          stop_d = stop_q + 1'b1;
          if (stop_q == STOP_LAST) begin
            data_d     = shreg_q;
            valid_d    = 1'b1;
            perr_out_d = perr_q;
            ferr_out_d = ferr_nx;
            state_d    = ferr_nx ? S_BREAK : S_IDLE;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: 8N1, 8E1 and 7O2 receivers at 16 clocks per bit.
module tb_uart_rx_param;

  localparam int BIT = 16;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;
  logic [7:0] data0, data1;
  logic [6:0] data2;
  logic valid0, valid1, valid2, perr0, perr1, perr2, ferr0, ferr1, ferr2, busy0, busy1, busy2;

  int checks = 0;
  int failures = 0;
  int unsigned cyc = 0;
  int unsigned t_prev2 = 0, t_last2 = 0;
  exp_t q0[$], q1[$], q2[$];

  int NB[3] = '{8, 8, 7};
  int PM[3] = '{0, 2, 1};
  int NS[3] = '{1, 1, 2};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_8n1 (
    .clk(clk), .rst(rst), .rx(rx0), .data_out(data0), .valid(valid0),
    .parity_err(perr0), .frame_err(ferr0), .busy(busy0));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .SYNC_STAGES(2)) dut_8e1 (
    .clk(clk), .rst(rst), .rx(rx1), .data_out(data1), .valid(valid1),
    .parity_err(perr1), .frame_err(ferr1), .busy(busy1));

  uart_rx_param #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) dut_7o2 (
    .clk(clk), .rst(rst), .rx(rx2), .data_out(data2), .valid(valid2),
    .parity_err(perr2), .frame_err(ferr2), .busy(busy2));

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic mon(input int cfg, input logic [8:0] d, input logic p, input logic f, input logic b);
    exp_t e;
    int sz;
    sz = (cfg == 0) ? q0.size() : (cfg == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_valid cfg%0d: got data=%0h expected no valid", cfg, d);
    end else begin
      if (cfg == 0)      e = q0.pop_front();
      else if (cfg == 1) e = q1.pop_front();
      else               e = q2.pop_front();
      chk($sformatf("data_cfg%0d", cfg), 32'(d), 32'(e.data));
      chk($sformatf("parity_err_cfg%0d", cfg), 32'(p), 32'(e.perr));
      chk($sformatf("frame_err_cfg%0d", cfg), 32'(f), 32'(e.ferr));
      // A clean frame returns to idle with the valid pulse; a bad stop bit goes to break.
      chk($sformatf("busy_at_valid_cfg%0d", cfg), 32'(b), 32'(e.ferr));
    end
  endtask

  always @(negedge clk) if (valid0) mon(0, {1'b0, data0}, perr0, ferr0, busy0);
  always @(negedge clk) if (valid1) mon(1, {1'b0, data1}, perr1, ferr1, busy1);
  always @(negedge clk) if (valid2) begin
    mon(2, {2'b0, data2}, perr2, ferr2, busy2);
    t_prev2 <= t_last2;
    t_last2 <= cyc;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int cfg, input logic v);
    case (cfg)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  // Reference: frame fields from the line protocol, parity from the count of ones.
  task automatic send_frame(input int cfg, input logic [8:0] data, input logic par_bit,
                            input logic [1:0] stops);
    exp_t e;
    logic [8:0] d;
    int nb, pm, ns;
    nb = NB[cfg]; pm = PM[cfg]; ns = NS[cfg];
    d = data & ((9'h1 << nb) - 9'h1);
    e.data = d;
    if (pm == 0)      e.perr = 1'b0;
    else if (pm == 2) e.perr = (par_bit != (^d));
    else              e.perr = (par_bit != ~(^d));
    e.ferr = !stops[0] || (ns == 2 && !stops[1]);
    if (cfg == 0)      q0.push_back(e);
    else if (cfg == 1) q1.push_back(e);
    else               q2.push_back(e);
    drive(cfg, 1'b0); step(BIT);
    for (int i = 0; i < nb; i++) begin drive(cfg, d[i]); step(BIT); end
    if (pm != 0) begin drive(cfg, par_bit); step(BIT); end
    for (int i = 0; i < ns; i++) begin drive(cfg, stops[i]); step(BIT); end
  endtask

  task automatic idle(input int cfg, input int n);
    drive(cfg, 1'b1);
    if (n > 0) step(n);
  endtask

  initial begin
    logic seen, cleared;
    logic [7:0] v;
    step(5);
    chk("reset_data_8n1", 32'(data0), 0);
    chk("reset_valid_8n1", 32'(valid0), 0);
    chk("reset_perr_8e1", 32'(perr1), 0);
    chk("reset_ferr_7o2", 32'(ferr2), 0);
    chk("reset_busy_7o2", 32'(busy2), 0);
    rst = 1'b0;
    step(5);

    send_frame(0, 9'h55, 1'b0, 2'b11); idle(0, 20);
    send_frame(1, 9'hA3, 1'b1, 2'b11); idle(1, 20);
    send_frame(1, 9'hA3, 1'b0, 2'b11); idle(1, 20);

    // Short low glitch: start rejected, no valid.
    seen = 1'b0; cleared = 1'b0;
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) begin step(1); seen |= busy0; end
    drive(0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      seen |= busy0;
      if (seen && !busy0) cleared = 1'b1;
    end
    chk("glitch_busy_seen", 32'(seen), 1);
    chk("glitch_busy_cleared", 32'(cleared), 1);
    step(40);

    // Stop bit held low for 40 cycles: framing error, then break until line high.
    send_frame(0, 9'h3C, 1'b0, 2'b10);
    step(24);
    chk("break_hold_busy", 32'(busy0), 1);
    drive(0, 1'b1);
    cleared = 1'b0;
    for (int i = 0; i < 8; i++) begin step(1); if (!busy0) cleared = 1'b1; end
    chk("break_exit", 32'(cleared), 1);
    step(10);
    send_frame(0, 9'h0F, 1'b0, 2'b11); idle(0, 20);

    // 7O2 back to back, odd parity bits correct.
    send_frame(2, 9'h12, ~(^7'h12), 2'b11);
    send_frame(2, 9'h7F, ~(^7'h7F), 2'b11);
    idle(2, 40);
    chk("b2b_interval_7o2", t_last2 - t_prev2, 11 * BIT);

    // Reset during data bit 4.
    v = 8'hA5;
    drive(0, 1'b0); step(BIT);
    for (int i = 0; i < 4; i++) begin drive(0, v[i]); step(BIT); end
    drive(0, v[4]); step(8);
    rst = 1'b1; drive(0, 1'b1);
    step(1);
    rst = 1'b0;
    chk("rst_mid_data", 32'(data0), 0);
    chk("rst_mid_valid", 32'(valid0), 0);
    chk("rst_mid_ferr", 32'(ferr0), 0);
    chk("rst_mid_busy", 32'(busy0), 0);
    step(200);
    send_frame(0, 9'hC3, 1'b0, 2'b11); idle(0, 20);

    // Randomised frames with occasional bad parity and stop bits.
    for (int cfg = 0; cfg < 3; cfg++) begin
      for (int n = 0; n < 10; n++) begin
        logic [8:0] d;
        logic pb;
        logic [1:0] st;
        int gap;
        d = 9'($urandom);
        pb = 1'($urandom);
        st[0] = ($urandom_range(0, 3) != 0);
        st[1] = ($urandom_range(0, 3) != 0);
        gap = $urandom_range(0, 20);
        send_frame(cfg, d, pb, st);
        if (!st[0] || (NS[cfg] == 2 && !st[1])) gap += 8;
        idle(cfg, gap);
      end
      idle(cfg, 40);
    end

    step(60);
    chk("pending_8n1", q0.size(), 0);
    chk("pending_8e1", q1.size(), 0);
    chk("pending_7o2", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
